// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcodes,
// datapath mux selects and the bundled control word.
package mips_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUB_REG  = 2'b00;  // register B
  localparam logic [1:0] ALUB_FOUR = 2'b01;  // constant 4 for PC+4
  localparam logic [1:0] ALUB_IMM  = 2'b10;  // sign-extended immediate
  localparam logic [1:0] ALUB_BRT  = 2'b11;  // shifted immediate, branch target

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       branch_ne;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       regwrite;
    logic       memtoreg;
    logic       jal;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_mem_timer.sv
// Counts consecutive not-ready cycles of a memory access; flags expiry once
// TIMEOUT wait cycles have elapsed. Any ready or state change clears it.
module mips_mem_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  assign expired = wait_en && (cnt == W'(TIMEOUT));

  // Count held wait cycles; the expiry cycle moves the FSM, so clear there too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (wait_en && !expired) cnt <= cnt + 1'b1;
    else                          cnt <= '0;
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM (Moore, with mem_ready qualification) plus
// memory-wait timeout and retired-instruction counter.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             branch_ne,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             regwrite,
  output logic             memtoreg,
  output logic             jal,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic [3:0]       state,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  logic [3:0] state_q, state_d;
  logic [5:0] op_q;
  ctrl_t      c, co;
  logic       illegal_d, retire, tmo, wait_en;

  assign wait_en = is_mem_state(state_q) && !mem_ready;

  mips_mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .wait_en (wait_en),
    .expired (tmo)
  );

  // Next-state and control decode; a timeout abandons the access with no write enables.
  always_comb begin
    c         = '0;
    state_d   = state_q;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        c.memread  = 1'b1;
        c.alusrcb  = ALUB_FOUR;
        c.pcsource = PCSRC_ALU;
        if (mem_ready) begin
          c.irwrite = 1'b1;
          c.pcwrite = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        c.alusrcb = ALUB_BRT;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J, OP_JAL:   state_d = S_JUMP;
          OP_ADDI:        state_d = S_ADDIEX;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUB_IMM;
        c.aluop   = ALUOP_ADD;
        state_d   = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else if (tmo)  state_d = S_FETCH;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (tmo) begin
          c.memwrite = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUB_REG;
        c.aluop   = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.aluop       = ALUOP_SUB;
        c.pcwritecond = 1'b1;
        c.pcsource    = PCSRC_ALUOUT;
        c.branch_ne   = (op_q == OP_BNE);
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_JUMP: begin
        c.pcwrite  = 1'b1;
        c.pcsource = PCSRC_JUMP;
        c.jal      = (op_q == OP_JAL);
        c.regwrite = (op_q == OP_JAL);
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUB_IMM;
        c.aluop   = ALUOP_ADD;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        c.regwrite = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every output low combinationally, not just at the next edge.
  assign co          = rst ? '0 : c;
  assign pcwrite     = co.pcwrite;
  assign pcwritecond = co.pcwritecond;
  assign branch_ne   = co.branch_ne;
  assign iord        = co.iord;
  assign memread     = co.memread;
  assign memwrite    = co.memwrite;
  assign irwrite     = co.irwrite;
  assign regdst      = co.regdst;
  assign regwrite    = co.regwrite;
  assign memtoreg    = co.memtoreg;
  assign jal         = co.jal;
  assign alusrca     = co.alusrca;
  assign alusrcb     = co.alusrcb;
  assign aluop       = co.aluop;
  assign pcsource    = co.pcsource;
  assign bus_err     = tmo & ~rst;
  assign illegal     = illegal_d & ~rst;
  assign state       = state_q;

  // State register, opcode latch (captured in DECODE) and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      instr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (retire) instr_cnt <= instr_cnt + 1'b1;
    end
  end

endmodule
